mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, 13, doubleword-index width of the data RAM (2^ADDR_W x 64-bit words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 req_re  input  1  MEM-stage load request (from EX/MEM register).
REQ-005 req_we  input  1  MEM-stage store request.
REQ-006 req_addr  input  64  byte address (EX/MEM ALU result).
REQ-007 req_wdata  input  64  store data, right-aligned.
REQ-008 req_func3  input  3  access size/sign code.
REQ-009 mem_stall  output  1  hold IF..MEM pipeline registers while high.
REQ-010 load_data  output  64  aligned, extended load result.
REQ-011 misaligned  output  1  request rejected for alignment or illegal func3.
REQ-012 ram_en  output  1  RAM port enable.
REQ-013 ram_we  output  8  RAM byte write enables; bit i = byte lane i.
REQ-014 ram_addr  output  ADDR_W  RAM doubleword index.
REQ-015 ram_wdata  output  64  RAM write data, lane-shifted.
REQ-016 ram_rdata  input  64  RAM read data, valid exactly one cycle after ram_en with ram_we=0.

Function
REQ-017 FSM states: IDLE, RD_WAIT, RD_DONE; only IDLE accepts requests.
REQ-018 ram_addr = req_addr[ADDR_W+2:3]; higher address bits are ignored.
REQ-019 Loads func3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 illegal.
REQ-020 Stores func3: 000 sb, 001 sh, 010 sw, 011 sd; 1xx illegal.
REQ-021 Alignment: half needs addr[0]=0, word addr[1:0]=0, double addr[2:0]=0; byte always aligned.
REQ-022 req_we and req_re both high: store performed, req_re ignored.
REQ-023 IDLE, legal aligned store: same cycle ram_en=1, ram_we = size mask shifted left by addr[2:0], ram_wdata = req_wdata shifted left by 8*addr[2:0]; mem_stall=0; remain IDLE.
REQ-024 IDLE, legal aligned load: same cycle ram_en=1, ram_we=0, mem_stall=1; latch addr[2:0] and func3; go RD_WAIT.
REQ-025 RD_WAIT: ram_en=0, mem_stall=1; register load_data = ram_rdata shifted right by 8*latched offset, then zero/sign-extended per latched func3; go RD_DONE.
REQ-026 RD_DONE: mem_stall=0, ram_en=0, request inputs ignored (same instruction still present); go IDLE. Load latency: 3 cycles, 2 stall cycles.
REQ-027 Misaligned or illegal request in IDLE: misaligned=1 combinationally that cycle, ram_en=0, ram_we=0, mem_stall=0, load_data unchanged.
REQ-028 misaligned=0 in RD_WAIT and RD_DONE.
REQ-029 No request in IDLE: ram_en=0, ram_we=0, mem_stall=0.
REQ-030 load_data holds its value until the next load reaches RD_WAIT.
REQ-031 ram_wdata = 0 whenever ram_we = 0.

Reset
REQ-032 resetn low: immediately state=IDLE, mem_stall=0, load_data=0, latched offset/func3=0; ram_en, ram_we, misaligned forced 0 while resetn is low.
REQ-033 Reset during RD_WAIT or RD_DONE abandons the load; no load_data update; first post-reset cycle behaves as IDLE.

Verification
REQ-034 sd addr 0x10, wdata 0x1122334455667788 -> same cycle ram_en=1, ram_we=0xFF, ram_addr=2, ram_wdata=0x1122334455667788, mem_stall=0.
REQ-035 sb addr 0x13, wdata 0xAB -> ram_we=0x08, ram_wdata=0x00000000AB000000, ram_addr=2.
REQ-036 RAM word 2 = 0x0000000080000000; lb addr 0x13 -> mem_stall high 2 cycles, load_data=0xFFFFFFFFFFFFFF80 in RD_DONE; lbu repeat -> 0x0000000000000080.
REQ-037 lw addr 0x12 -> misaligned=1 one cycle, ram_en=0, mem_stall=0, load_data unchanged; func3=111 load -> same response.
REQ-038 Two back-to-back ld (addr 0x0 then 0x8) with request held through RD_DONE -> exactly two ram_en pulses, 6 cycles total, no reissue in RD_DONE.
REQ-039 resetn driven low mid-RD_WAIT -> mem_stall=0 and load_data=0 before next clock edge; after release, new sd issues normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit for a synchronous 64-bit data RAM
// Stores complete in one cycle; loads take three cycles, two of them stalled.
module mem_access_unit #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [2:0]        req_func3,
  output logic              mem_stall,
  output logic [63:0]       load_data,
  output logic              misaligned,
  output logic              ram_en,
  output logic [7:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  input  logic [63:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  off_q, off_d;
  logic [2:0]  func3_q, func3_d;
  logic [63:0] load_data_q, load_data_d;

  logic        is_store, is_load, legal, aligned, ok;
  logic [7:0]  size_mask;
  logic [63:0] shifted, extended;
  logic        stall_c, en_c, mis_c;
  logic [7:0]  we_c;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[63:ADDR_W+3];

  // A simultaneous store and load request is treated as a store.
  assign is_store = req_we;
  assign is_load  = req_re & ~req_we;
  assign legal    = is_store ? ~req_func3[2] : (req_func3 != 3'b111);
  assign ok       = legal & aligned;

  always_comb begin
    aligned   = 1'b1;
    size_mask = 8'h01;
    case (req_func3[1:0])
      2'd0: begin aligned = 1'b1;                  size_mask = 8'h01; end
      2'd1: begin aligned = ~req_addr[0];          size_mask = 8'h03; end
      2'd2: begin aligned = (req_addr[1:0] == 2'd0); size_mask = 8'h0F; end
      default: begin aligned = (req_addr[2:0] == 3'd0); size_mask = 8'hFF; end
    endcase
  end

  assign shifted = ram_rdata >> {off_q, 3'b000};

  always_comb begin
    extended = shifted;
    case (func3_q)
      3'b000:  extended = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  extended = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  extended = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  extended = {56'd0, shifted[7:0]};
      3'b101:  extended = {48'd0, shifted[15:0]};
      3'b110:  extended = {32'd0, shifted[31:0]};
      default: extended = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    func3_d     = func3_q;
    load_data_d = load_data_q;
    stall_c     = 1'b0;
    en_c        = 1'b0;
    we_c        = 8'h00;
    mis_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_store || is_load) begin
          if (!ok) begin
            mis_c = 1'b1;
          end else if (is_store) begin
            en_c = 1'b1;
            we_c = size_mask << req_addr[2:0];
          end else begin
            en_c    = 1'b1;
            stall_c = 1'b1;
            off_d   = req_addr[2:0];
            func3_d = req_func3;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall_c     = 1'b1;
        load_data_d = extended;
        state_d     = RD_DONE;
      end
      // The stalled instruction is still presented here; it must not reissue.
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      off_q       <= 3'd0;
      func3_q     <= 3'd0;
      load_data_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      func3_q     <= func3_d;
      load_data_q <= load_data_d;
    end
  end

  assign mem_stall  = resetn & stall_c;
  assign ram_en     = resetn & en_c;
  assign misaligned = resetn & mis_c;
  assign ram_we     = resetn ? we_c : 8'h00;
  assign ram_addr   = req_addr[ADDR_W+2:3];
  assign ram_wdata  = (ram_we == 8'h00) ? 64'd0 : (req_wdata << {req_addr[2:0], 3'b000});
  assign load_data  = load_data_q;

endmodule
